// File: rtl/power_pkg.sv
// Shared constants and helpers for the iterative power unit.
package power_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_BUSY = 2'd1;
    localparam logic [STATE_W-1:0] S_DONE = 2'd2;

    // Ceiling log2, usable in constant expressions; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/power_unit_if.sv
// Operand/result handshake bundle between source, power unit and consumer.
interface power_unit_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned EXP_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_base;
    logic [EXP_W-1:0]  in_exp;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_ovf;
    logic              busy;

    modport master (
        output in_valid, in_base, in_exp, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_base, in_exp, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/power_ctrl.sv
// Sequencer for the power unit: IDLE/BUSY/DONE FSM and exponent down-counter.
module power_ctrl
    import power_pkg::*;
#(
    parameter int unsigned EXP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_valid,
    input  logic [EXP_W-1:0] i_exp,
    input  logic             i_out_ready,
    output logic             o_in_ready,
    output logic             o_busy,
    output logic             o_out_valid,
    output logic             o_acc_load_c,
    output logic             o_acc_step_c,
    output logic             o_fin_c
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [EXP_W-1:0]   r_cnt;
    logic [EXP_W-1:0]   w_cnt_nxt;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_out_valid;
    logic               w_acc_load;
    logic               w_acc_step;
    logic               w_fin;

    // Next-state and datapath strobes; w_fin marks the edge that enters DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_load  = 1'b0;
        w_acc_step  = 1'b0;
        w_fin       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid) begin
                    w_acc_load = 1'b1;
                    w_cnt_nxt  = i_exp;
                    if (i_exp == '0) begin
                        w_state_nxt = S_DONE;
                        w_fin       = 1'b1;
                    end else begin
                        w_state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                w_acc_step = 1'b1;
                w_cnt_nxt  = r_cnt - EXP_W'(1);
                if (r_cnt == EXP_W'(1)) begin
                    w_state_nxt = S_DONE;
                    w_fin       = 1'b1;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake outputs are flops mirroring the next state, so they decode registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt == S_BUSY);
            r_out_valid <= (w_state_nxt == S_DONE);
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_busy       = r_busy;
    assign o_out_valid  = r_out_valid;
    assign o_acc_load_c = w_acc_load;
    assign o_acc_step_c = w_acc_step;
    assign o_fin_c      = w_fin;

endmodule

// File: rtl/power_unit.sv
// Iterative p**q engine: operand latch, accumulator, multiplier and sticky overflow.
module power_unit
    import power_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned EXP_W  = 4
) (
    input  logic         clk,
    input  logic         rst,
    power_unit_if.slave  bus
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic [DATA_W-1:0] r_base;
    logic [DATA_W-1:0] r_acc;
    logic              r_ovf;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_ovf;

    logic [PROD_W-1:0] w_prod;
    logic [DATA_W-1:0] w_prod_lo;
    logic [DATA_W-1:0] w_prod_hi;
    logic              w_ovf_nxt;
    logic              w_acc_load;
    logic              w_acc_step;
    logic              w_fin;

    power_ctrl #(
        .EXP_W (EXP_W)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .i_in_valid   (bus.in_valid),
        .i_exp        (bus.in_exp),
        .i_out_ready  (bus.out_ready),
        .o_in_ready   (bus.in_ready),
        .o_busy       (bus.busy),
        .o_out_valid  (bus.out_valid),
        .o_acc_load_c (w_acc_load),
        .o_acc_step_c (w_acc_step),
        .o_fin_c      (w_fin)
    );

    assign w_prod    = PROD_W'(r_acc) * PROD_W'(r_base);
    assign w_prod_lo = w_prod[DATA_W-1:0];
    assign w_prod_hi = w_prod[PROD_W-1:DATA_W];
    // Once wrapped, the low bits alone can no longer reveal overflow, so keep it sticky for p>1.
    assign w_ovf_nxt = (w_prod_hi != '0) | (r_ovf & (r_base > DATA_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else begin
            if (w_acc_load) begin
                r_base <= bus.in_base;
                r_acc  <= DATA_W'(1);
                r_ovf  <= 1'b0;
            end else if (w_acc_step) begin
                r_acc  <= w_prod_lo;
                r_ovf  <= w_ovf_nxt;
            end
            // Result registers change only on entry to DONE and hold through the idle gap.
            if (w_fin) begin
                if (w_acc_load) begin
                    r_out_data <= DATA_W'(1);
                    r_out_ovf  <= 1'b0;
                end else begin
                    r_out_data <= w_prod_lo;
                    r_out_ovf  <= w_ovf_nxt;
                end
            end
        end
    end

    assign bus.out_data = r_out_data;
    assign bus.out_ovf  = r_out_ovf;

endmodule
